intmul_arbiter: RTL and testbench
=================================

// Module: intmul_arbiter
// PURPOSE
// Shares one pipelined intmul multiplier (fixed latency MUL_LAT) between NUM_REQ requesters.
// Uses a round-robin grant with valid/ready handshakes on both the request and result sides.
// A per-operation ID tag travels alongside the operands through the pipeline.
// Results land in an output FIFO with credit-based issue control, so back-pressure on
// res_ready never drops an in-flight product. Sits between the NTT butterfly lanes and the
// shared intmul instance.
// PARAMETERS
// LOGQ        64  operand width; product width is 2*LOGQ
// NUM_REQ     4   number of requesters (>=1)
// MUL_LAT     2   intmul latency in cycles, from mul_a/mul_b to mul_c
// FIFO_DEPTH  4   result FIFO entries; full throughput requires FIFO_DEPTH >= MUL_LAT+2
// ID_W        derived localparam: max(1, clog2(NUM_REQ))
// PORTS
// clk        in   1              rising-edge clock
// rst        in   1              asynchronous, active-low reset
// req_valid  in   NUM_REQ        per-requester request valid
// req_ready  out  NUM_REQ        one-hot grant; bit i is high only if req_valid[i] is high
// req_a      in   NUM_REQ*LOGQ   operand A; requester i uses slice [i*LOGQ +: LOGQ]
// req_b      in   NUM_REQ*LOGQ   operand B, same slicing as req_a
// mul_a      out  LOGQ           registered operand A to intmul.in_a
// mul_b      out  LOGQ           registered operand B to intmul.in_b
// mul_c      in   2*LOGQ         intmul.out_c
// res_valid  out  1              FIFO head is valid
// res_ready  in   1              consumer accepts the head
// res_data   out  2*LOGQ         product at the FIFO head
// res_id     out  ID_W           requester index of the head
// busy       out  1              high when any operation is outstanding (in flight or in FIFO)
// BEHAVIOUR
// - Reset (rst=0, async):
//   - clears rr_ptr, the tag pipe, the FIFO pointers and the outstanding counter.
//   - drives res_valid=0, busy=0, mul_a=0, mul_b=0, req_ready=0.
//   - in-flight operations are discarded.
// - Credit:
//   - cnt = operations accepted but not yet popped from the FIFO.
//   - pop = res_valid & res_ready.
//   - Issue is allowed iff (cnt - pop) < FIFO_DEPTH; a pop in the same cycle frees a credit.
// - Arbitration:
//   - If issue is allowed, grant the first i with req_valid[i] set, searching from rr_ptr
//     upward with wrap.
//   - req_ready is combinational from req_valid, rr_ptr and cnt; at most one bit is high.
// - Handshake and pointer update:
//   - A handshake is req_valid[i] & req_ready[i] at a rising edge.
//   - On handshake: rr_ptr <= (i+1) mod NUM_REQ; mul_a/mul_b <= the operands of i;
//     tag pipe stage 0 <= {1, i}.
//   - With no handshake, mul_a/mul_b hold their value and a bubble (valid=0) enters the tag pipe.
//   - Requesters hold valid and data until accepted; retracting a request is illegal.
// - Tag pipe: MUL_LAT stages of {valid, id}, aligned so that a tag exits together with its
//   mul_c. The exiting tag pushes {mul_c, id} into the FIFO.
// - Latency: handshake at edge k -> res_valid high after edge k+MUL_LAT+1, if the FIFO was empty.
// - FIFO:
//   - first-word fall-through; res_data/res_id stay stable while res_valid & !res_ready.
//   - push and pop in the same cycle are both honoured.
//   - the credit rule guarantees no push is ever made while full; this is checked by assertion.
// - Ordering: results leave in issue order; products are never reordered or dropped.
// - Counter: cnt <= cnt + issue - pop; range 0..FIFO_DEPTH; busy = (cnt != 0).
// - NUM_REQ=1: rr_ptr is constant 0 and res_id is 0.
// TESTING
// 1. Single request: req_valid[0]=1, a=3, b=5, res_ready=1 -> handshake at edge k;
//    res_valid after edge k+3 with res_data=15, res_id=0; busy falls the cycle after the pop.
// 2. All four requesters valid, res_ready=1 -> grants 0,1,2,3,0,...; one handshake and one
//    result per cycle; res_id sequence 0,1,2,3,...
// 3. All valid, res_ready=0 -> exactly 4 handshakes, then req_ready=0 and cnt=4. Raise
//    res_ready -> 4 results in issue order, then issuing resumes with no lost or duplicated
//    product.
// 4. a = b = 2^64-1 -> res_data = 2^128 - 2^65 + 1 (0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001).
// 5. Requesters 0 and 2 both held valid -> grants alternate 0,2,0,2; requesters 1 and 3
//    never get req_ready.
// 6. rst=0 with 3 operations in flight -> res_valid=0, busy=0 immediately. After release,
//    a new request from requester 3 completes correctly; no stale result appears.

Source files
------------

// File: rtl/intmul_arbiter.sv
// Round-robin front end that shares one pipelined intmul between NUM_REQ requesters.
// Products return through a credit-controlled first-word-fall-through FIFO, tagged by requester.
module intmul_arbiter #(
  parameter int LOGQ       = 64,
  parameter int NUM_REQ    = 4,
  parameter int MUL_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*LOGQ-1:0] req_a,
  input  logic [NUM_REQ*LOGQ-1:0] req_b,
  output logic [LOGQ-1:0]         mul_a,
  output logic [LOGQ-1:0]         mul_b,
  input  logic [2*LOGQ-1:0]       mul_c,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*LOGQ-1:0]       res_data,
  output logic [ID_W-1:0]         res_id,
  output logic                    busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ID_W:0]    NUM_REQ_C = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  logic                run_q;
  logic [ID_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]    cnt;
  logic                pop;
  logic                push;
  logic                can_issue;
  logic                issue;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;

  // Entry 0 sits beside mul_a/mul_b; entries 1..MUL_LAT shadow the multiplier stages,
  // so tag_pipe[MUL_LAT] leaves in the same cycle as the matching mul_c.
  tag_t tag_pipe [0:MUL_LAT];

  logic [2*LOGQ+ID_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign res_valid = (fifo_cnt != '0);
  assign pop       = res_valid & res_ready;
  assign push      = tag_pipe[MUL_LAT].valid;
  assign busy      = (cnt != '0);

  // A pop at this edge returns a credit that the same edge may spend.
  assign can_issue = run_q && ((cnt - CNT_W'(pop)) < DEPTH_C);

  always_comb begin
    logic [ID_W:0] idx;
    logic          found;
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(j);
      if (idx >= NUM_REQ_C) idx = idx - NUM_REQ_C;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found                  = 1'b1;
        grant[idx[ID_W-1:0]]   = 1'b1;
        grant_id               = idx[ID_W-1:0];
      end
    end
    if (!can_issue) begin
      grant    = '0;
      grant_id = '0;
    end
  end

  assign req_ready = grant;
  assign issue     = |grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q    <= 1'b0;
      rr_ptr   <= '0;
      cnt      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int s = 0; s <= MUL_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every stage sees pre-edge values.
      run_q <= 1'b1;
      if (issue) begin
        rr_ptr <= next_id(grant_id);
        mul_a  <= req_a[grant_id*LOGQ +: LOGQ];
        mul_b  <= req_b[grant_id*LOGQ +: LOGQ];
      end
      tag_pipe[0] <= '{valid: issue, id: grant_id};
      for (int s = 1; s <= MUL_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
      cnt <= cnt + CNT_W'(issue) - CNT_W'(pop);
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and fifo_cnt alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {mul_c, tag_pipe[MUL_LAT].id};
  end

  assign {res_data, res_id} = fifo_mem[rd_ptr];

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (fifo_cnt == DEPTH_C)));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst) cnt <= DEPTH_C);
  a_fifo_within_credit: assert property (@(posedge clk) disable iff (!rst) fifo_cnt <= cnt);
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(req_ready) && ((req_ready & ~req_valid) == '0));

endmodule

// File: tb/tb_intmul_arbiter.sv
// Scoreboard bench for intmul_arbiter: directed vectors with hand-computed products,
// a behavioural 2-cycle multiplier and a decoupled result monitor.
module tb_intmul_arbiter;

  localparam int LOGQ    = 64;
  localparam int NUM_REQ = 4;

  typedef struct packed {
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] p;
  } vec_t;

  typedef struct packed {
    logic [1:0]   id;
    logic [127:0] p;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*LOGQ-1:0] req_a;
  logic [NUM_REQ*LOGQ-1:0] req_b;
  logic [LOGQ-1:0]         mul_a;
  logic [LOGQ-1:0]         mul_b;
  logic [2*LOGQ-1:0]       mul_c;
  logic [2*LOGQ-1:0]       mul_p1;
  logic                    res_valid;
  logic                    res_ready;
  logic [2*LOGQ-1:0]       res_data;
  logic [1:0]              res_id;
  logic                    busy;

  intmul_arbiter #(.LOGQ(64), .NUM_REQ(4), .MUL_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared intmul: two register stages, never reset.
  always @(posedge clk) begin
    mul_p1 <= {64'b0, mul_a} * {64'b0, mul_b};
    mul_c  <= mul_p1;
  end

  vec_t       pend [NUM_REQ][$];
  int         exp_grant[$];
  exp_t       sb[$];
  logic [3:0] hs_pend = '0;
  logic       res_ready_nxt = 1'b0;
  int         cyc = 0;
  int         hs_total = 0;
  int         first_hs, last_hs;
  int         pop_total = 0;
  int         first_pop, last_pop;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add_vec(input int r, input logic [63:0] a, input logic [63:0] b,
                         input logic [127:0] p);
    pend[r].push_back('{a: a, b: b, p: p});
  endtask

  task automatic refresh();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_a[i*LOGQ +: LOGQ] = pend[i][0].a;
        req_b[i*LOGQ +: LOGQ] = pend[i][0].b;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++) if (pend[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: retire last cycle's handshakes, drive inputs, observe this cycle's grant.
  task automatic run_cycle();
    logic [3:0] hs;
    int         idx;
    int         exp_id;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) if (hs_pend[i] && pend[i].size() > 0) pend[i].delete(0);
    res_ready = res_ready_nxt;
    refresh();
    #1;
    check("ready_legal", 128'($onehot0(req_ready) && ((req_ready & ~req_valid) == 4'b0)), 128'(1));
    hs      = req_valid & req_ready;
    hs_pend = hs;
    if (hs != 4'b0) begin
      idx = 0;
      for (int i = 0; i < NUM_REQ; i++) if (hs[i]) idx = i;
      hs_total++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      if (exp_grant.size() == 0) begin
        check("grant_unexpected", 128'(hs), 128'(0));
      end else begin
        exp_id = exp_grant.pop_front();
        check("grant_order", 128'(idx), 128'(exp_id));
        sb.push_back('{id: 2'(exp_id), p: pend[idx][0].p});
      end
    end
  endtask

  task automatic wait_hs(input string name, input int target, input int bound);
    int t = 0;
    while (hs_total < target && t < bound) begin
      run_cycle();
      t++;
    end
    check(name, 128'(hs_total >= target), 128'(1));
  endtask

  task automatic run_until_idle(input string name, input int bound);
    int t = 0;
    while (t < bound && !(all_empty() && hs_pend == 4'b0 && sb.size() == 0 && !busy)) begin
      run_cycle();
      t++;
    end
    check(name, 128'(t < bound), 128'(1));
  endtask

  // Result monitor: compares every FIFO pop with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("stray_result", 128'(res_valid), 128'(0));
        end else begin
          e = sb.pop_front();
          check("res_id", 128'(res_id), 128'(e.id));
          check("res_data", res_data, e.p);
        end
        pop_total++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst       = 1'b0;
    req_valid = 4'hF;
    req_a     = '1;
    req_b     = '1;
    res_ready = 1'b0;
    first_hs  = -1;
    first_pop = -1;
    #3;
    check("rst_res_valid", 128'(res_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_mul_a", 128'(mul_a), 128'(0));
    check("rst_mul_b", 128'(mul_b), 128'(0));
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single request 3*5 with latency and busy timing.
    res_ready_nxt = 1'b1;
    add_vec(0, 64'd3, 64'd5, 128'd15);
    exp_grant.push_back(0);
    wait_hs("t1_handshake", 1, 10);
    run_cycle(); check("t1_lat_c1", 128'(res_valid), 128'(0));
    run_cycle(); check("t1_lat_c2", 128'(res_valid), 128'(0));
    run_cycle(); check("t1_lat_c3", 128'(res_valid), 128'(0));
    run_cycle();
    check("t1_valid_c4", 128'(res_valid), 128'(1));
    check("t1_busy_c4", 128'(busy), 128'(1));
    check("t1_data", res_data, 128'd15);
    run_cycle();
    check("t1_busy_fall", 128'(busy), 128'(0));
    check("t1_valid_fall", 128'(res_valid), 128'(0));

    // Max operands on requester 3: (2^64-1)^2.
    add_vec(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    exp_grant.push_back(3);
    run_until_idle("t4_idle", 30);

    // All four valid, full throughput, rr from 0.
    add_vec(0, 64'd2, 64'd3, 128'd6);      add_vec(0, 64'd7, 64'd11, 128'd77);
    add_vec(1, 64'd4, 64'd5, 128'd20);     add_vec(1, 64'd13, 64'd17, 128'd221);
    add_vec(2, 64'd6, 64'd7, 128'd42);     add_vec(2, 64'd19, 64'd23, 128'd437);
    add_vec(3, 64'd8, 64'd9, 128'd72);     add_vec(3, 64'd100, 64'd1000, 128'd100000);
    for (int k = 0; k < 8; k++) exp_grant.push_back(k % 4);
    base = hs_total; first_hs = -1; first_pop = -1; pop_total = 0;
    run_until_idle("t2_idle", 60);
    check("t2_hs_count", 128'(hs_total - base), 128'(8));
    check("t2_hs_back_to_back", 128'(last_hs - first_hs), 128'(7));
    check("t2_pop_count", 128'(pop_total), 128'(8));
    check("t2_pop_back_to_back", 128'(last_pop - first_pop), 128'(7));

    // Back-pressure: credits run out after four issues, then drain and resume.
    res_ready_nxt = 1'b0;
    add_vec(0, 64'd1000, 64'd1000, 128'd1000000);  add_vec(0, 64'd3, 64'd3, 128'd9);
    add_vec(1, 64'd12, 64'd12, 128'd144);          add_vec(1, 64'd5, 64'd6, 128'd30);
    add_vec(2, 64'd255, 64'd255, 128'd65025);      add_vec(2, 64'd9, 64'd9, 128'd81);
    add_vec(3, 64'h1_0000_0000, 64'h1_0000_0000, 128'h1_0000_0000_0000_0000);
    add_vec(3, 64'd0, 64'd12345, 128'd0);
    for (int k = 0; k < 8; k++) exp_grant.push_back(k % 4);
    base = hs_total; pop_total = 0;
    repeat (10) run_cycle();
    check("t3_stall_hs", 128'(hs_total - base), 128'(4));
    check("t3_stall_ready", 128'(req_ready), 128'(0));
    check("t3_stall_busy", 128'(busy), 128'(1));
    check("t3_head_valid", 128'(res_valid), 128'(1));
    check("t3_head_id", 128'(res_id), 128'(0));
    check("t3_head_data", res_data, 128'd1000000);
    repeat (3) run_cycle();
    check("t3_head_stable_id", 128'(res_id), 128'(0));
    check("t3_head_stable_data", res_data, 128'd1000000);
    res_ready_nxt = 1'b1;
    run_until_idle("t3_idle", 60);
    check("t3_hs_total", 128'(hs_total - base), 128'(8));
    check("t3_pop_total", 128'(pop_total), 128'(8));

    // Requesters 0 and 2 only: grants alternate.
    add_vec(0, 64'd21, 64'd2, 128'd42);
    add_vec(0, 64'd50, 64'd50, 128'd2500);
    add_vec(0, 64'hFFFF_FFFF, 64'd2, 128'h1_FFFF_FFFE);
    add_vec(2, 64'd1, 64'd1, 128'd1);
    add_vec(2, 64'd99, 64'd99, 128'd9801);
    add_vec(2, 64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000);
    for (int k = 0; k < 6; k++) exp_grant.push_back((k % 2) * 2);
    base = hs_total;
    run_until_idle("t5_idle", 60);
    check("t5_hs_count", 128'(hs_total - base), 128'(6));

    // Reset with three operations in flight; stale products must not surface.
    res_ready_nxt = 1'b0;
    add_vec(0, 64'd11, 64'd11, 128'd121);
    add_vec(1, 64'd12, 64'd12, 128'd144);
    add_vec(2, 64'd13, 64'd13, 128'd169);
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    base = hs_total;
    wait_hs("t6_three_issued", base + 3, 20);
    run_cycle();
    check("t6_busy_before", 128'(busy), 128'(1));
    rst = 1'b0;
    #1;
    check("t6_rst_res_valid", 128'(res_valid), 128'(0));
    check("t6_rst_busy", 128'(busy), 128'(0));
    check("t6_rst_req_ready", 128'(req_ready), 128'(0));
    check("t6_rst_mul_a", 128'(mul_a), 128'(0));
    for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
    exp_grant.delete();
    sb.delete();
    hs_pend = '0;
    refresh();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    res_ready_nxt = 1'b1;
    add_vec(3, 64'd6, 64'd7, 128'd42);
    exp_grant.push_back(3);
    base = hs_total; pop_total = 0;
    run_until_idle("t6_idle", 30);
    repeat (8) run_cycle();
    check("t6_hs_count", 128'(hs_total - base), 128'(1));
    check("t6_pop_count", 128'(pop_total), 128'(1));
    check("t6_sb_empty", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
